// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct encodings, write-back destination kinds and instruction field positions
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int SH_MSB = 10;
    localparam int SH_LSB = 6;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;

    typedef enum logic [1:0] {NONE, GPR_RD, GPR_RT, HILO} wb_dest_e;
    typedef enum logic [1:0] {SEL_ALU, SEL_HI, SEL_LO, SEL_MEM} wb_sel_e;

endpackage

// File: rtl/wb_dest_decode.sv
// wb_dest_decode: maps an instruction to its write-back destination kind, register address and data source
module wb_dest_decode
    import mips_pkg::*;
(
    input  logic [31:0] instr,
    output wb_dest_e    kind,
    output logic [4:0]  addr,
    output wb_sel_e     sel
);
    logic [5:0] op, fn;
    logic       unused_fields;

    assign op = instr[OP_MSB:OP_LSB];
    assign fn = instr[FN_MSB:FN_LSB];
    assign unused_fields = ^{instr[RS_MSB:RS_LSB], instr[SH_MSB:SH_LSB]};

    always_comb begin
        kind = NONE;
        addr = instr[RD_MSB:RD_LSB];
        sel  = SEL_ALU;
        case (op)
            OP_RTYPE: begin
                if (fn inside {FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                               FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                               FN_XOR, FN_NOR, FN_SLT, FN_SLTU})
                    kind = GPR_RD;
                else if (fn == FN_MFHI || fn == FN_MFLO) begin
                    kind = GPR_RD;
                    sel  = fn == FN_MFHI ? SEL_HI : SEL_LO;
                end else if (fn inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU})
                    kind = HILO;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                kind = GPR_RT;
                addr = instr[RT_MSB:RT_LSB];
            end
            OP_LW: begin
                kind = GPR_RT;
                addr = instr[RT_MSB:RT_LSB];
                sel  = SEL_MEM;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_regfile_wb.sv
// mips_regfile_wb: write-back latch, GPR/HI/LO state and forwarded ALU operands
module mips_regfile_wb
    import mips_pkg::*;
#(
    parameter int          NREGS     = 32,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_result,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [31:0] mem_rdata,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic [31:0] gr1,
    output logic [31:0] gr2,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data
);
    logic [31:0] gpr [NREGS];
    logic [31:0] hi_r, lo_r, wb_hi, wb_lo, data_d;
    logic        hilo_we, gpr_we_d, hilo_we_d;
    logic [4:0]  dest;
    wb_dest_e    kind;
    wb_sel_e     sel;

    wb_dest_decode u_dec (
        .instr(ex_instr),
        .kind (kind),
        .addr (dest),
        .sel  (sel)
    );

    assign gpr_we_d  = ex_valid && (kind == GPR_RD || kind == GPR_RT) && dest != 5'd0;
    assign hilo_we_d = ex_valid && kind == HILO;
    assign hi_out    = hilo_we ? wb_hi : hi_r;
    assign lo_out    = hilo_we ? wb_lo : lo_r;
    assign data_d    = sel == SEL_HI  ? hi_out :
                       sel == SEL_LO  ? lo_out :
                       sel == SEL_MEM ? mem_rdata : ex_result;

    // r0 may hold RESET_VAL in the array, so the zero-address check must win
    assign gr1 = rs_addr == 5'd0 ? 32'd0 :
                 (wb_valid && wb_addr == rs_addr) ? wb_data : gpr[rs_addr];
    assign gr2 = rt_addr == 5'd0 ? 32'd0 :
                 (wb_valid && wb_addr == rt_addr) ? wb_data : gpr[rt_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) gpr[i] <= RESET_VAL;
            hi_r     <= RESET_VAL;
            lo_r     <= RESET_VAL;
            wb_valid <= 1'b0;
            wb_addr  <= 5'd0;
            wb_data  <= 32'd0;
            hilo_we  <= 1'b0;
            wb_hi    <= 32'd0;
            wb_lo    <= 32'd0;
        end else begin
            if (wb_valid) gpr[wb_addr] <= wb_data;
            if (hilo_we) begin
                hi_r <= wb_hi;
                lo_r <= wb_lo;
            end
            wb_valid <= gpr_we_d;
            wb_addr  <= gpr_we_d ? dest : 5'd0;
            wb_data  <= gpr_we_d ? data_d : 32'd0;
            hilo_we  <= hilo_we_d;
            wb_hi    <= ex_hi;
            wb_lo    <= ex_lo;
        end
    end
endmodule

// File: tb/tb_mips_regfile_wb.sv
// tb_mips_regfile_wb: directed and random checks of the write-back stage against an architectural model
module tb_mips_regfile_wb;
    logic        clk = 1'b0, rst_n = 1'b0, ex_valid = 1'b0;
    logic [31:0] ex_instr = '0, ex_result = '0, ex_hi = '0, ex_lo = '0, mem_rdata = '0;
    logic [4:0]  rs_addr = '0, rt_addr = '0;
    logic [31:0] gr1, gr2, hi_out, lo_out, wb_data;
    logic        wb_valid;
    logic [4:0]  wb_addr;

    int n_checks = 0, n_errors = 0;

    logic [31:0] arch [32];
    logic [31:0] mhi, mlo, exp_wbd;
    logic        exp_wbv;
    logic [4:0]  exp_wba;

    mips_regfile_wb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_valid (ex_valid),
        .ex_instr (ex_instr),
        .ex_result(ex_result),
        .ex_hi    (ex_hi),
        .ex_lo    (ex_lo),
        .mem_rdata(mem_rdata),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .gr1      (gr1),
        .gr2      (gr2),
        .hi_out   (hi_out),
        .lo_out   (lo_out),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // architectural view: a write is visible from the edge it is presented at
    task automatic model_reset();
        for (int i = 0; i < 32; i++) arch[i] = 32'd0;
        mhi = 32'd0;
        mlo = 32'd0;
        exp_wbv = 1'b0;
        exp_wba = 5'd0;
        exp_wbd = 32'd0;
    endtask

    task automatic model_step(input logic v, input logic [31:0] i, input logic [31:0] res,
                              input logic [31:0] h, input logic [31:0] l, input logic [31:0] mem);
        int          dest;
        logic [31:0] val;
        logic [5:0]  op, fn;
        dest = -1;
        val = res;
        op = i[31:26];
        fn = i[5:0];
        exp_wbv = 1'b0;
        exp_wba = 5'd0;
        exp_wbd = 32'd0;
        if (v) begin
            if (op == 6'h00) begin
                if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B})
                    dest = int'(i[15:11]);
                else if (fn == 6'h10) begin
                    dest = int'(i[15:11]);
                    val = mhi;
                end else if (fn == 6'h12) begin
                    dest = int'(i[15:11]);
                    val = mlo;
                end else if (fn inside {[6'h18:6'h1B]}) begin
                    mhi = h;
                    mlo = l;
                end
            end else if (op inside {[6'h08:6'h0E]})
                dest = int'(i[20:16]);
            else if (op == 6'h23) begin
                dest = int'(i[20:16]);
                val = mem;
            end
            if (dest > 0) begin
                arch[dest] = val;
                exp_wbv = 1'b1;
                exp_wba = 5'(dest);
                exp_wbd = val;
            end
        end
    endtask

    // called at a negedge; checks current state, then presents one result across the next posedge
    task automatic cycle(input logic v, input logic [31:0] i, input logic [31:0] res,
                         input logic [31:0] h, input logic [31:0] l, input logic [31:0] mem,
                         input logic [4:0] ra, input logic [4:0] rb);
        ex_valid = v;
        ex_instr = i;
        ex_result = res;
        ex_hi = h;
        ex_lo = l;
        mem_rdata = mem;
        rs_addr = ra;
        rt_addr = rb;
        #1;
        check("wb_valid", 32'(wb_valid), 32'(exp_wbv));
        if (exp_wbv) begin
            check("wb_addr", 32'(wb_addr), 32'(exp_wba));
            check("wb_data", wb_data, exp_wbd);
        end
        check("gr1", gr1, arch[ra]);
        check("gr2", gr2, arch[rb]);
        check("hi_out", hi_out, mhi);
        check("lo_out", lo_out, mlo);
        @(posedge clk);
        model_step(v, i, res, h, l, mem);
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
        cycle(1'b0, $urandom, $urandom, $urandom, $urandom, $urandom, ra, rb);
    endtask

    task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
        rs_addr = a;
        #1;
        check(tag, gr1, exp);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [4:0] s, t, d;
        logic [5:0] fn;
        logic [5:0] alu_fn [16];
        alu_fn = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                   6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};
        s = 5'($urandom_range(0, 7));
        t = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 7))
            0: fn = alu_fn[$urandom_range(0, 15)];
            1: fn = 6'h10;
            2: fn = 6'h12;
            3: fn = 6'(24 + $urandom_range(0, 3));
            4: return {6'(8 + $urandom_range(0, 6)), s, t, 16'($urandom)};
            5: return {6'h23, s, t, 16'($urandom)};
            6: return {($urandom_range(0, 2) == 0) ? 6'h04 : ($urandom_range(0, 1) == 0) ? 6'h05 : 6'h2B,
                       s, t, 16'($urandom)};
            default: return $urandom;
        endcase
        return {6'h00, s, t, d, 5'($urandom), fn};
    endfunction

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rs_addr = 5'($urandom);
        rt_addr = 5'($urandom);
        #1;
        check("rst_gr1", gr1, 32'd0);
        check("rst_gr2", gr2, 32'd0);
        check("rst_hi", hi_out, 32'd0);
        check("rst_lo", lo_out, 32'd0);
        check("rst_wbv", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        cycle(1'b1, 32'h0001_1020, 32'h1E1E_1E1D, $urandom, $urandom, $urandom, 5'd0, 5'd0);
        peek("add_fwd", 5'd2, 32'h1E1E_1E1D);
        idle(5'd2, 5'd1);
        peek("add_array", 5'd2, 32'h1E1E_1E1D);

        cycle(1'b1, 32'h2000_FFFF, 32'h7FFF_FFFE, $urandom, $urandom, $urandom, 5'd0, 5'd0);
        #1;
        check("addi_r0_wbv", 32'(wb_valid), 32'd0);
        peek("addi_r0", 5'd0, 32'd0);

        cycle(1'b1, 32'h0001_0018, $urandom, 32'hFFFF_FFFF, 32'hFFFF_FFFF, $urandom, 5'd2, 5'd0);
        #1;
        check("mult_wbv", 32'(wb_valid), 32'd0);
        check("mult_lo_fwd", lo_out, 32'hFFFF_FFFF);
        cycle(1'b1, 32'h0000_2812, $urandom, $urandom, $urandom, $urandom, 5'd0, 5'd0);
        peek("mflo_r5", 5'd5, 32'hFFFF_FFFF);
        idle(5'd5, 5'd2);

        cycle(1'b1, 32'h8C41_0020, $urandom, $urandom, $urandom, 32'hCAFE_F00D, 5'd1, 5'd2);
        peek("lw_r1", 5'd1, 32'hCAFE_F00D);
        cycle(1'b1, 32'h1022_0003, $urandom, $urandom, $urandom, $urandom, 5'd1, 5'd2);
        cycle(1'b1, 32'hAC41_0004, $urandom, $urandom, $urandom, $urandom, 5'd1, 5'd2);
        #1;
        check("sw_wbv", 32'(wb_valid), 32'd0);
        peek("beq_sw_r1", 5'd1, 32'hCAFE_F00D);
        peek("beq_sw_r2", 5'd2, 32'h1E1E_1E1D);

        cycle(1'b1, 32'h0000_1820, 32'd5, $urandom, $urandom, $urandom, 5'd3, 5'd0);
        peek("r3_fwd", 5'd3, 32'd5);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_drop_wbv", 32'(wb_valid), 32'd0);
        peek("rst_drop_r3", 5'd3, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(5'd3, 5'd2);
        peek("post_rst_r3", 5'd3, 32'd0);
        cycle(1'b1, 32'h0000_2020, 32'h1234_5678, $urandom, $urandom, $urandom, 5'd0, 5'd0);
        peek("first_edge_r4", 5'd4, 32'h1234_5678);

        for (int n = 0; n < 3000; n++)
            cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom, $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
